seq_gen_core: RTL

- Parametrised Fibonacci/timer sequence generator core. It is the next generation of the board-level start_f/start_t/stop_f_t/update/prog sequence unit.
- Generalised over value width, prescaler base and programming width.
- Adds overflow detection, a DONE state and a per-value valid strobe.
- Sits between the debounced button/switch inputs and the display/LED drivers, which consume value, parity and state.

---
 rtl/seq_gen_core.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_gen_core.sv
// Fibonacci / timer sequence generator with programmable tick prescaler, overflow detect and DONE state.
// Optional: define SEQ_AUTORESTART_EN to reload the sequence on overflow instead of entering DONE.
module seq_gen_core #(
   parameter int WIDTH    = 16,
   parameter int PROG_W   = 3,
   parameter int BASE_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_f,
   input  logic              start_t,
   input  logic              stop_f_t,
   input  logic              update,
   input  logic [PROG_W-1:0] prog,
   output logic [WIDTH-1:0]  value,
   output logic              value_valid,
   output logic              parity,
   output logic [1:0]        state,
   output logic              overflow
);

   localparam int PW = PROG_W + $clog2(BASE_DIV + 1) + 1;

   typedef enum logic [1:0] {IDLE = 2'b00, FIB = 2'b01, TMR = 2'b10, DONE = 2'b11} state_t;

   state_t            st, st_nx;
   logic [WIDTH-1:0]  b, b_nx, value_nx;
   logic [PROG_W-1:0] prog_reg;
   logic [PW-1:0]     presc, presc_nx, period;
   logic              ov_nx, vv_nx, running, tick;
   logic [WIDTH:0]    fsum, tsum;

   assign period  = PW'((32'(prog_reg) + 32'd1) * 32'(BASE_DIV));
   assign running = (st == FIB) || (st == TMR);
   // >= rather than == so a shortened period fires immediately instead of wrapping the long way
   assign tick    = running && (presc >= period - PW'(1));
   assign fsum    = {1'b0, value} + {1'b0, b};
   assign tsum    = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      st_nx    = st;
      value_nx = value;
      b_nx     = b;
      presc_nx = presc;
      ov_nx    = overflow;
      vv_nx    = 1'b0;
      if (running)
         presc_nx = tick ? '0 : presc + PW'(1);
      if (stop_f_t) begin
         st_nx = IDLE;
      end else if (!running && (start_f || start_t)) begin
         value_nx = '0;
         presc_nx = '0;
         ov_nx    = 1'b0;
         vv_nx    = 1'b1;
         if (start_f) begin
            st_nx = FIB;
            b_nx  = WIDTH'(1);
         end else begin
            st_nx = TMR;
         end
      end else if (tick) begin
         vv_nx = 1'b1;
         if (st == FIB) begin
            if (!fsum[WIDTH]) begin
               value_nx = b;
               b_nx     = fsum[WIDTH-1:0];
            end else begin
               ov_nx = 1'b1;
`ifdef SEQ_AUTORESTART_EN
               value_nx = '0;
               b_nx     = WIDTH'(1);
`else
               value_nx = b;
               st_nx    = DONE;
`endif
            end
         end else begin
            value_nx = tsum[WIDTH-1:0];
`ifdef SEQ_AUTORESTART_EN
            if (tsum[WIDTH])
               ov_nx = 1'b1;
`else
            if (tsum == {1'b0, {WIDTH{1'b1}}}) begin
               st_nx = DONE;
               ov_nx = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st          <= IDLE;
         value       <= '0;
         b           <= '0;
         prog_reg    <= '0;
         presc       <= '0;
         value_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         st          <= st_nx;
         value       <= value_nx;
         b           <= b_nx;
         presc       <= presc_nx;
         value_valid <= vv_nx;
         overflow    <= ov_nx;
         if (update)
            prog_reg <= prog;
      end
   end

   assign parity = ^value;
   assign state  = st;

endmodule
